// File: rtl/ram512_arbiter.sv
// ram512_arbiter: two-port round-robin arbiter serialising single-word commands onto one ram512.
module ram512_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, rr_ptr_q, rr_ptr_d, cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic gnt1, hs, access;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end
  // Port 1 wins only when it is alone or it is its turn.
  always_comb begin
    access       = (state_q == ACCESS);
    gnt1         = req1_valid & (~req0_valid | rr_ptr_q);
    req0_ready   = (state_q == IDLE) & req0_valid & ~gnt1;
    req1_ready   = (state_q == IDLE) & gnt1;
    hs           = req0_ready | req1_ready;
    state_d      = access ? IDLE : (hs ? ACCESS : IDLE);
    owner_d      = hs ? gnt1 : owner_q;
    rr_ptr_d     = hs ? ~gnt1 : rr_ptr_q;
    cmd_we_d     = hs ? (gnt1 ? req1_we : req0_we) : cmd_we_q;
    cmd_addr_d   = hs ? (gnt1 ? req1_addr : req0_addr) : cmd_addr_q;
    cmd_wdata_d  = hs ? (gnt1 ? req1_wdata : req0_wdata) : cmd_wdata_q;
    rsp0_valid_d = access & ~owner_q;
    rsp1_valid_d = access & owner_q;
    rsp0_rdata_d = (rsp0_valid_d & ~cmd_we_q) ? ram_out : rsp0_rdata_q;
    rsp1_rdata_d = (rsp1_valid_d & ~cmd_we_q) ? ram_out : rsp1_rdata_q;
  end
  // Load is decoded from state so an async reset kills a pending write at once.
  assign ram_load    = access & cmd_we_q;
  assign ram_address = cmd_addr_q;
  assign ram_in      = cmd_wdata_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rdata  = rsp0_rdata_q;
  assign rsp1_rdata  = rsp1_rdata_q;
endmodule

// File: tb/tb_ram512_arbiter.sv
// tb_ram512_arbiter: directed self-checking bench with a behavioural ram512 behind the arbiter.
module tb_ram512_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req0_ready, req0_we = 0, rsp0_valid;
  logic [8:0] req0_addr = '0;
  logic [15:0] req0_wdata = '0, rsp0_rdata;
  logic req1_valid = 0, req1_ready, req1_we = 0, rsp1_valid;
  logic [8:0] req1_addr = '0;
  logic [15:0] req1_wdata = '0, rsp1_rdata;
  logic ram_load;
  logic [8:0] ram_address;
  logic [15:0] ram_in, ram_out;
  logic [15:0] mem [512];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  ram512_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One command on a single port; exp_rdata is what rsp_rdata must show after completion.
  task automatic issue(input bit p, input bit we, input logic [8:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rdata);
    if (p) begin
      req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d;
    end
    #1;
    for (int i = 0; i < 10 && !(p ? req1_ready : req0_ready); i++) step();
    check("grant", {req1_ready, req0_ready}, p ? 2'b10 : 2'b01);
    step();
    req0_valid = 0; req1_valid = 0;
    check("acc_ready", {req1_ready, req0_ready}, 0);
    check("acc_load", ram_load, we);
    check("acc_addr", ram_address, a);
    check("acc_in", ram_in, d);
    step();
    check("rsp_valid", {rsp1_valid, rsp0_valid}, p ? 2'b10 : 2'b01);
    check("rsp_rdata", p ? rsp1_rdata : rsp0_rdata, exp_rdata);
    check("idle_load", ram_load, 0);
    step();
    check("rsp_pulse_end", {rsp1_valid, rsp0_valid}, 0);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 16'hA000 + 16'(i);
      mem[32 + i] = 16'hB000 + 16'(i);
    end
    mem[7] = 16'h0777;
    #12 rst_n = 1;
    step();
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_load", ram_load, 0);
    check("rst_addr", ram_address, 0);
    check("rst_in", ram_in, 0);
    check("rst_rsp", {rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata}, 0);
    issue(0, 1, 9'd2, 16'hABCD, 16'h0000);
    check("addr_hold", ram_address, 9'd2);
    check("in_hold", ram_in, 16'hABCD);
    issue(0, 0, 9'd2, 16'h0000, 16'hABCD);
    issue(1, 1, 9'h1FF, 16'h1234, 16'h0000);
    issue(1, 0, 9'h1FF, 16'h0000, 16'h1234);
    issue(1, 0, 9'd0, 16'h0000, 16'h0000);
    // Contention: last grant went to port 1, so port 0 goes first.
    req0_we = 0; req1_we = 0; req0_addr = 9'd16; req1_addr = 9'd32;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("cont_grant", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        check("cont_rsp_valid", {rsp1_valid, rsp0_valid}, ((k - 1) % 2) ? 2'b10 : 2'b01);
        check("cont_rsp_data", ((k - 1) % 2) ? rsp1_rdata : rsp0_rdata,
              (((k - 1) % 2) ? 16'hB000 : 16'hA000) + 16'((k - 1) / 2));
      end
      step();
      check("cont_acc_ready", {req1_ready, req0_ready}, 0);
      if (k % 2) begin
        if (k / 2 == 3) req1_valid = 0; else req1_addr = 9'(32 + k / 2 + 1);
      end else begin
        if (k / 2 == 3) req0_valid = 0; else req0_addr = 9'(16 + k / 2 + 1);
      end
      step();
    end
    check("cont_last_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    check("cont_last_data", rsp1_rdata, 16'hB003);
    check("cont_hold0", rsp0_rdata, 16'hA003);
    step();
    // rr_ptr = 0 but only port 1 asks: immediate grant; then port 0 wins the tie.
    req1_valid = 1; req1_addr = 9'h1FF;
    #1;
    check("solo1_grant", {req1_ready, req0_ready}, 2'b10);
    step();
    req0_valid = 1; req0_addr = 9'd16; req1_addr = 9'd33;
    step();
    check("tie_grant0", {req1_ready, req0_ready}, 2'b01);
    check("solo1_rsp", {rsp1_valid, rsp1_rdata}, {1'b1, 16'h1234});
    step();
    req0_valid = 0;
    step();
    check("tie_then1", {req1_ready, req0_ready}, 2'b10);
    check("tie_rsp0", {rsp0_valid, rsp0_rdata}, {1'b1, 16'hA000});
    step();
    req1_valid = 0;
    step();
    check("tie_rsp1", {rsp1_valid, rsp1_rdata}, {1'b1, 16'hB001});
    step();
    // Reset in the middle of a write access.
    req0_valid = 1; req0_we = 1; req0_addr = 9'd7; req0_wdata = 16'h5555;
    #1;
    check("rst_mid_grant", req0_ready, 1);
    step();
    req0_valid = 0;
    check("rst_mid_load_pre", ram_load, 1);
    rst_n = 0;
    #1;
    check("rst_mid_load_drop", ram_load, 0);
    step();
    check("rst_mid_norsp", {rsp1_valid, rsp0_valid}, 0);
    rst_n = 1;
    req0_we = 0; req1_we = 0; req1_addr = 9'd0;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("post_rst_rr", {req1_ready, req0_ready}, 2'b01);
    step();
    req0_valid = 0;
    step();
    check("post_rst_rsp0", {rsp0_valid, rsp0_rdata}, {1'b1, 16'h0777});
    check("post_rst_grant1", {req1_ready, req0_ready}, 2'b10);
    step();
    req1_valid = 0;
    step();
    check("post_rst_rsp1", {rsp1_valid, rsp1_rdata}, {1'b1, 16'h0000});
    check("mem7_kept", mem[7], 16'h0777);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  always @(negedge clk) if (req0_ready && req1_ready) check("both_ready", 1, 0);
endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one ram512 instance.
- Each requester issues single-word read/write commands over a valid/ready handshake.
- The arbiter serialises the commands onto the ram512 load/address/in pins, returns read data with a one-cycle response pulse, and alternates fairly under contention.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 16, RAM data width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_we  input  1  1 = write, 0 = read
- req0_addr  input  ADDR_W  requester 0 word address
- req0_wdata  input  DATA_W  requester 0 write data
- rsp0_valid  output  1  one-cycle completion pulse to requester 0
- rsp0_rdata  output  DATA_W  read data to requester 0
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for requester 1
- ram_load  output  1  to ram512 load
- ram_address  output  ADDR_W  to ram512 address
- ram_in  output  DATA_W  to ram512 in
- ram_out  input  DATA_W  from ram512 out; combinational read of ram_address

Behaviour:
- Clock and reset:
  - One clock.
  - rst_n is asynchronous and active-low.
- State machine:
  - Two states, IDLE and ACCESS.
  - Registers: owner, rr_ptr, cmd_we_q, cmd_addr_q, cmd_wdata_q.
- Reset values:
  - State = IDLE, rr_ptr = 0 (requester 0 favoured), owner = 0.
  - cmd_* = 0, rsp0/1_valid = 0, rsp0/1_rdata = 0.
  - ram_load = 0, ram_address = 0, ram_in = 0.
- IDLE, grant selection:
  - Only one reqN_valid high: grant N.
  - Both high: grant rr_ptr.
- IDLE, ready:
  - reqN_ready = 1 combinationally for the granted N only. It is never high outside IDLE and never high for both ports.
- IDLE, handshake (valid & ready at the edge):
  - Latch we/addr/wdata into cmd_*, owner = N, rr_ptr = ~N.
  - Go to ACCESS.
- IDLE with no valid: stay in IDLE; rr_ptr unchanged.
- ACCESS (exactly one cycle):
  - ram_address = cmd_addr_q, ram_in = cmd_wdata_q, ram_load = cmd_we_q.
  - At the closing edge the write commits inside ram512.
  - On a read, rsp[owner]_rdata <= ram_out.
  - rsp[owner]_valid <= 1.
  - Next state is IDLE.
- ram_load:
  - Decoded as (state == ACCESS) & cmd_we_q.
  - Must be 0 in IDLE and immediately 0 when reset asserts.
- ram_address and ram_in hold the last command's values in IDLE (no glitching to 0).
- Response:
  - rspN_valid is registered and high for exactly the one cycle after ACCESS. That cycle is IDLE, so the next grant can overlap it.
  - Writes pulse rspN_valid but leave rspN_rdata unchanged.
  - rspN_rdata holds its value until the next read completion for N.
- Throughput and latency:
  - At most one command per 2 cycles.
  - Read latency: 2 edges from handshake to rsp_valid high.
- Fairness:
  - With both ports continuously valid, grants strictly alternate 0,1,0,1…
  - No requester waits more than one other command.
- Requester inputs are sampled only at the handshake edge. Changes during ACCESS are ignored.
- Reset mid-ACCESS:
  - Command aborted, no write commits (load drops asynchronously).
  - No rsp pulse; return to IDLE with rr_ptr = 0.
- Address wrap: none; the full 0…511 range is legal, including 9'h1FF.

Test Plan:
- Reset, then req0 write addr 2 data 16'hABCD → req0_ready high 1 cycle; next cycle ram_load=1, ram_address=2, ram_in=ABCD; following cycle rsp0_valid=1, rsp0_rdata still 0.
- req0 read addr 2 after above → rsp0_valid pulse 2 edges after handshake with rsp0_rdata=16'hABCD; ram_load stays 0.
- req1 write 16'h1234 to 9'h1FF, then req1 read 9'h1FF → rsp1_rdata=16'h1234; read of addr 0 (never written) → 16'h0000, assuming the RAM was initialised to 0.
- Both valid continuously, 4 reads each from distinct addresses → grant order 0,1,0,1,…; each rsp pulse lands on the correct port with the correct data; ready never high on both ports.
- Only req1 valid with rr_ptr=0 → req1 granted immediately; then both valid → req0 granted next.
- Assert rst_n low during ACCESS of a write of 16'h5555 to addr 7 → ram_load falls immediately, no rsp pulse; a later read of addr 7 returns its prior value.
